serial_dp_ram: RTL and testbench
================================

Name: serial_dp_ram

Overview:
- True dual-port synchronous RAM, 2048 words x 12 bits, two independent read/write ports A and B on one clock.
- Serves as the frame buffer in the radar serial output path.
- The serializer writes FFT magnitude pairs through both ports at once, to addresses n and n+1.
- It then reads words back through port A for bit-serial transmission.

Parameters:
- DATA_W, 12, word width in bits.
- ADDR_W, 11, address width in bits.
- DEPTH, 2**ADDR_W (2048), number of words. All addresses are valid; there is no out-of-range case.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset; clears output registers only.
- data_a  input  DATA_W  port A write data.
- addr_a  input  ADDR_W  port A address.
- we_a  input  1  port A write enable.
- q_a  output  DATA_W  port A registered read data.
- data_b  input  DATA_W  port B write data.
- addr_b  input  ADDR_W  port B address.
- we_b  input  1  port B write enable.
- q_b  output  DATA_W  port B registered read data.

Behaviour:
- Reset:
  - reset_n low forces q_a and q_b to 0 immediately, independent of clk, and holds them at 0 while reset is low.
  - Memory array contents are not reset; they are undefined until written.
  - Reset has no effect on memory writes already committed. A write on an edge where reset_n is low is ignored.
- Write: at a rising edge with we_x=1, mem[addr_x] <= data_x.
- Read:
  - Every rising edge (reset_n high), q_x <= mem[addr_x]. Read latency is 1 cycle.
  - Reads happen regardless of we_x.
- Same-port read-during-write: read-first. q_x shows the old contents of addr_x; new data is visible on the next read.
- Cross-port collision, both ports writing the same address on the same edge: port B data is stored and port A's write is discarded.
- Cross-port read of an address written by the other port on the same edge: returns old data. New data is visible from the following edge.
- Address arithmetic belongs to the caller; the RAM applies no wrap or offset. A caller computing addr+1 at 2047 presents 0 (11-bit wrap), and the RAM accesses word 0.
- q outputs hold their value only as long as the address is held; there is no read-enable and no hold.

Optional Feature:
- Macro SERIAL_DP_RAM_OUT_REG_EN.
- When defined:
  - An additional output pipeline register is added per port, making read latency 2 cycles.
  - The extra register is also cleared asynchronously by reset_n.
  - Collision rules are unchanged and are evaluated at the array edge.
- When undefined: read latency is 1 cycle as above.

Decomposition:
- Package serial_dp_ram_pkg holds DATA_W=12, ADDR_W=11 and DEPTH=2048 as localparams.
- The serializer and the RAM both import the package.
- One sub-module is natural: serial_dp_ram_oreg, the per-port output register with async clear.
  - It is instantiated once per port, and twice per port in the chained configuration when SERIAL_DP_RAM_OUT_REG_EN is defined.

Test Plan:
- Reset: drive reset_n=0 mid-cycle while q_a=0xABC -> q_a and q_b become 0x000 without waiting for a clock edge, and stay 0 until reset_n=1 plus one edge.
- Dual write/readback:
  - Write A: addr 10 <= 0x123 and B: addr 11 <= 0x456 in the same cycle, then read A@10 and B@11.
  - -> q_a=0x123 and q_b=0x456 exactly one edge after the addresses are presented (two edges with SERIAL_DP_RAM_OUT_REG_EN).
- Full sweep:
  - Write pairs (n, n+1) for n=0,2,...,2046 with data=address.
  - Then read port A at 0..2047. -> q_a equals the address at every word, including word 2047=0x7FF.
- Read-first:
  - mem[5]=0x0AA. Write A addr 5 <= 0x055 with addr_a=5 held.
  - -> q_a=0x0AA after that edge and 0x055 after the next edge.
- Write collision: A and B both write addr 100, data 0x111 (A) and 0xFFF (B) -> a subsequent read of 100 returns 0xFFF.
- Cross-port read:
  - mem[200]=0x300. B writes 0x0F0 to 200 while A reads 200.
  - -> q_a=0x300 on that edge and 0x0F0 on the next.

Source files
------------

// File: rtl/serial_dp_ram_pkg.sv
// Shared sizing for the radar serial-output frame buffer.
// Imported by the RAM, its output register and the serializer.
package serial_dp_ram_pkg;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2 ** ADDR_W;
endpackage

// File: rtl/serial_dp_ram_oreg.sv
// Per-port output register for serial_dp_ram.
// Cleared asynchronously by reset_n.
module serial_dp_ram_oreg
  import serial_dp_ram_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/serial_dp_ram.sv
// True dual-port 2048x12 frame buffer: read-first on each port, port B wins write collisions.
// Define SERIAL_DP_RAM_OUT_REG_EN for an extra output stage per port (2-cycle read latency).
module serial_dp_ram
  import serial_dp_ram_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              we_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // Port B is assigned last so its write wins when both ports hit the same word.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (we_a) begin
        mem[addr_a] <= data_a;
      end
      if (we_b) begin
        mem[addr_b] <= data_b;
      end
    end
  end

  // Output stages sample the array before this edge's writes land, giving read-first.
  assign rd_a = mem[addr_a];
  assign rd_b = mem[addr_b];

`ifdef SERIAL_DP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] stage_a;
  logic [DATA_W-1:0] stage_b;

  serial_dp_ram_oreg #(.W(DATA_W)) u_oreg_a0 (.clk(clk), .reset_n(reset_n), .d(rd_a),    .q(stage_a));
  serial_dp_ram_oreg #(.W(DATA_W)) u_oreg_a1 (.clk(clk), .reset_n(reset_n), .d(stage_a), .q(q_a));
  serial_dp_ram_oreg #(.W(DATA_W)) u_oreg_b0 (.clk(clk), .reset_n(reset_n), .d(rd_b),    .q(stage_b));
  serial_dp_ram_oreg #(.W(DATA_W)) u_oreg_b1 (.clk(clk), .reset_n(reset_n), .d(stage_b), .q(q_b));
`else
  serial_dp_ram_oreg #(.W(DATA_W)) u_oreg_a (.clk(clk), .reset_n(reset_n), .d(rd_a), .q(q_a));
  serial_dp_ram_oreg #(.W(DATA_W)) u_oreg_b (.clk(clk), .reset_n(reset_n), .d(rd_b), .q(q_b));
`endif

endmodule

// File: tb/tb_serial_dp_ram.sv
// Randomized self-checking bench for serial_dp_ram against a word-array reference model.
// Honours SERIAL_DP_RAM_OUT_REG_EN for the expected read latency.
module tb_serial_dp_ram;

  localparam int DW = 12;
  localparam int AW = 11;
  localparam int NW = 2048;
`ifdef SERIAL_DP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    bit          valid;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] data_a, data_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          we_a, we_b;
  logic [DW-1:0] q_a, q_b;

  logic [DW-1:0] model_mem [NW];
  bit            written   [NW];
  exp_t          hist_a [$];
  exp_t          hist_b [$];

  int checks = 0;
  int errors = 0;

  serial_dp_ram dut (
    .clk(clk), .reset_n(reset_n),
    .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .q_a(q_a),
    .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .q_b(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, update the model at the edge, check #1 later.
  task automatic applyStimulus(input bit wa, input int aa, input int da,
                               input bit wb, input int ab, input int db);
    exp_t ea, eb;
    we_a = wa; addr_a = AW'(aa); data_a = DW'(da);
    we_b = wb; addr_b = AW'(ab); data_b = DW'(db);
    @(posedge clk);
    if (reset_n) begin
      ea.valid = written[addr_a]; ea.data = model_mem[addr_a];
      eb.valid = written[addr_b]; eb.data = model_mem[addr_b];
      hist_a.push_back(ea);
      hist_b.push_back(eb);
      if (wa) begin model_mem[addr_a] = data_a; written[addr_a] = 1'b1; end
      if (wb) begin model_mem[addr_b] = data_b; written[addr_b] = 1'b1; end
    end
    #1;
    if (!reset_n) begin
      checkOutput("q_a_in_reset", q_a, '0);
      checkOutput("q_b_in_reset", q_b, '0);
    end else begin
      if (hist_a.size() == LAT) begin
        ea = hist_a.pop_front();
        if (ea.valid) checkOutput("q_a", q_a, ea.data);
      end
      if (hist_b.size() == LAT) begin
        eb = hist_b.pop_front();
        if (eb.valid) checkOutput("q_b", q_b, eb.data);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a, b;
    reset_n = 1'b0;
    we_a = 0; we_b = 0; addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    for (int i = 0; i < NW; i++) begin written[i] = 1'b0; model_mem[i] = '0; end

    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Dual write then readback
    applyStimulus(1, 10, 'h123, 1, 11, 'h456);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(0, 10, 0, 0, 11, 0);

    // Read-first on port A
    applyStimulus(1, 5, 'h0AA, 0, 0, 0);
    applyStimulus(1, 5, 'h055, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(0, 5, 0, 0, 5, 0);

    // Same-address write collision
    applyStimulus(1, 100, 'h111, 1, 100, 'hFFF);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(0, 100, 0, 0, 100, 0);

    // Cross-port read of a word being written by B
    applyStimulus(1, 200, 'h300, 0, 0, 0);
    applyStimulus(0, 200, 0, 1, 200, 'h0F0);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(0, 200, 0, 0, 200, 0);

    // Full sweep: pairs (n, n+1) with data = address, then read everything
    for (int n = 0; n < NW; n += 2) applyStimulus(1, n, n, 1, n + 1, n + 1);
    for (int n = 0; n < NW; n++) applyStimulus(0, n, 0, 0, NW - 1 - n, 0);
    for (int i = 0; i < LAT; i++) applyStimulus(0, 2047, 0, 0, 0, 0);

    // Randomized traffic over a narrow window to provoke collisions and wrap pairs
    for (int i = 0; i < 2000; i++) begin
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2040, 2047)) : int'($urandom_range(0, 15));
      b = ($urandom_range(0, 1) == 0) ? ((a + 1) % NW) : int'($urandom_range(0, 15));
      applyStimulus(bit'($urandom_range(0, 1)), a, int'($urandom_range(0, 4095)),
                    bit'($urandom_range(0, 1)), b, int'($urandom_range(0, 4095)));
    end
    for (int i = 0; i < LAT; i++) applyStimulus(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle, write during reset ignored
    applyStimulus(1, 7, 'hABC, 1, 300, 'h111);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(0, 7, 0, 0, 300, 0);
    checkOutput("pre_reset_q_a", q_a, 12'hABC);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_q_a", q_a, '0);
    checkOutput("async_reset_q_b", q_b, '0);
    hist_a.delete();
    hist_b.delete();
    @(negedge clk);
    applyStimulus(1, 300, 'h5A5, 1, 7, 'h5A5);
    applyStimulus(0, 7, 0, 0, 300, 0);
    reset_n = 1'b1;
    #1;
    checkOutput("release_q_a", q_a, '0);
    checkOutput("release_q_b", q_b, '0);
    @(negedge clk);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(0, 300, 0, 0, 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
